// File: rtl/adc_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_reader_pkg
//  Description : Shared constants, state encoding and control-word helper for
//                the 8-channel 12-bit serial ADC read controller.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_reader_pkg;

    localparam int c_FRAME_BITS      = 16;  // SCLK periods per frame
    localparam int c_DATA_BITS       = 12;  // conversion result width
    localparam int c_CH_BITS         = 3;   // channel address width
    localparam int c_PERIOD_W        = 4;   // width of the SCLK period index
    localparam int c_ADDR_MSB        = 13;  // address field in the control word
    localparam int c_ADDR_LSB        = 11;
    localparam int c_CLK_DIV_DEFAULT = 26;  // 50 MHz / 26 ~= 1.92 MHz SCLK

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_STOP  = 3'd3,
        ST_QUIET = 3'd4
    } state_t;

    // Control word sent MSB first: {2'b00, ch, 11'b0}
    function automatic logic [c_FRAME_BITS-1:0] ctrl_word(input logic [c_CH_BITS-1:0] ch);
        logic [c_FRAME_BITS-1:0] w_word;
        w_word = '0;
        w_word[c_ADDR_MSB:c_ADDR_LSB] = ch;
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_reader_if
//  Description : User-side request/result signals plus ADC pin signals of the
//                serial ADC read controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface adc_reader_if;
    import adc_reader_pkg::*;

    logic                   en;
    logic [c_CH_BITS-1:0]   ch;
    logic [c_DATA_BITS-1:0] adc_data;
    logic [c_CH_BITS-1:0]   adc_ch;
    logic                   adc_done;
    logic                   adc_state;
    logic                   adc_cs_n;
    logic                   adc_sclk;
    logic                   adc_din;
    logic                   adc_dout;

    // Controller side
    modport slave (
        input  en, ch, adc_dout,
        output adc_data, adc_ch, adc_done, adc_state, adc_cs_n, adc_sclk, adc_din
    );

    // User logic and ADC side
    modport master (
        output en, ch, adc_dout,
        input  adc_data, adc_ch, adc_done, adc_state, adc_cs_n, adc_sclk, adc_din
    );
endinterface
`default_nettype wire

// File: rtl/adc_reader_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sclk_gen
//  Description : Half-period counter generating the ADC serial clock.
//                o_fall_stb is a look-ahead strobe: asserted the cycle before
//                SCLK is driven low, so data can change together with SCLK.
//                o_rise_stb is asserted in the first cycle SCLK is high, which
//                is the DOUT sample point. o_period counts periods 0..15 and
//                holds the current period index whenever o_fall_stb is high.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_sclk_gen
    import adc_reader_pkg::*;
#(
    parameter int HALF = 13
) (
    input  logic                  clk_50mhz,
    input  logic                  rst_n,
    input  logic                  i_run,
    output logic                  o_sclk,
    output logic                  o_fall_stb,
    output logic                  o_rise_stb,
    output logic [c_PERIOD_W-1:0] o_period
);

    localparam int                c_CNT_W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HALF - 1);

    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_sclk;
    logic                  r_rise;
    logic [c_PERIOD_W-1:0] r_period;
    logic                  w_edge;

    // SCLK toggles at the start of every half-period while running
    assign w_edge     = i_run && (r_cnt == '0);
    assign o_fall_stb = w_edge && r_sclk;
    assign o_rise_stb = r_rise;
    assign o_sclk     = r_sclk;
    assign o_period   = r_period;

    // Half-period counter, SCLK level, period index; parked high when idle
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_sclk   <= 1'b1;
            r_rise   <= 1'b0;
            r_period <= '0;
        end else if (!i_run) begin
            r_cnt    <= '0;
            r_sclk   <= 1'b1;
            r_rise   <= 1'b0;
            r_period <= '0;
        end else begin
            r_rise <= w_edge && !r_sclk;
            if (w_edge) begin
                r_sclk <= !r_sclk;
            end
            if (w_edge && !r_sclk) begin
                r_period <= r_period + 1'b1;
            end
            if (r_cnt == c_CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_reader.sv
`default_nettype none
// ============================================================================
//  Module      : adc_reader
//  Description : Serial ADC read controller. One en pulse runs a 16-SCLK
//                frame that addresses the next channel and captures the
//                current 12-bit conversion, reported with an adc_done pulse.
//                CLK_DIV must be even and at least 4.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_reader
    import adc_reader_pkg::*;
#(
    parameter int CLK_DIV = c_CLK_DIV_DEFAULT
) (
    input  logic        clk_50mhz,
    input  logic        rst_n,
    adc_reader_if.slave bus
);

    localparam int                c_HALF       = CLK_DIV / 2;
    localparam int                c_TMR_W      = $clog2(c_FRAME_BITS * CLK_DIV);
    localparam logic [c_TMR_W-1:0] c_HALF_LAST  = c_TMR_W'(c_HALF - 1);
    localparam logic [c_TMR_W-1:0] c_SHIFT_LAST = c_TMR_W'(2 * c_FRAME_BITS * c_HALF - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_TMR_W-1:0]      r_tmr;
    logic                    w_accept;
    logic                    w_frame_end;
    logic [c_CH_BITS-1:0]    r_ch_lat;
    logic [c_CH_BITS-1:0]    r_prev_ch;
    logic [c_DATA_BITS-1:0]  r_shift;
    logic                    r_cs_n;
    logic                    r_din;
    logic                    r_done;
    logic                    r_busy;
    logic [c_DATA_BITS-1:0]  r_data;
    logic [c_CH_BITS-1:0]    r_ch;
    logic [c_FRAME_BITS-1:0] w_ctrl;
    logic                    w_sclk_run;
    logic                    w_sclk;
    logic                    w_sclk_fall;
    logic                    w_sclk_rise;
    logic [c_PERIOD_W-1:0]   w_period;
    logic [c_PERIOD_W-1:0]   w_bit_idx;

    // SCLK is driven from the next state so its first fall lines up with
    // the first SHIFT cycle instead of lagging one clock behind it.
    assign w_sclk_run = (w_state_nxt == ST_SHIFT);
    assign w_ctrl     = ctrl_word(r_ch_lat);
    assign w_bit_idx  = c_PERIOD_W'(c_FRAME_BITS - 1) - w_period;

    adc_sclk_gen #(
        .HALF (c_HALF)
    ) u_sclk_gen (
        .clk_50mhz  (clk_50mhz),
        .rst_n      (rst_n),
        .i_run      (w_sclk_run),
        .o_sclk     (w_sclk),
        .o_fall_stb (w_sclk_fall),
        .o_rise_stb (w_sclk_rise),
        .o_period   (w_period)
    );

    // State register and per-state cycle timer
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_tmr <= '0;
            end else if (r_state != ST_IDLE) begin
                r_tmr <= r_tmr + 1'b1;
            end
        end
    end

    // Next-state decode: START/STOP/QUIET last H cycles, SHIFT 32H cycles
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.en) begin
                    w_state_nxt = ST_START;
                    w_accept    = 1'b1;
                end
            end
            ST_START: begin
                if (r_tmr == c_HALF_LAST) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_tmr == c_SHIFT_LAST) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (r_tmr == c_HALF_LAST) begin
                    w_state_nxt = ST_QUIET;
                    w_frame_end = 1'b1;
                end
            end
            ST_QUIET: begin
                if (r_tmr == c_HALF_LAST) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pin drive, serial shift and result/tag registers.
    // The sample register is only as wide as the result: the ADC's four
    // leading bits fall off the top as the last twelve bits shift in.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_lat  <= '0;
            r_prev_ch <= '0;
            r_shift   <= '0;
            r_cs_n    <= 1'b1;
            r_din     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_data    <= '0;
            r_ch      <= '0;
        end else begin
            r_done <= 1'b0;
            r_busy <= (w_state_nxt != ST_IDLE);
            r_cs_n <= !((w_state_nxt == ST_START) || (w_state_nxt == ST_SHIFT) ||
                        (w_state_nxt == ST_STOP));
            if (w_accept) begin
                r_ch_lat <= bus.ch;
            end
            if (w_sclk_fall) begin
                r_din <= w_ctrl[w_bit_idx];
            end else if (w_state_nxt != ST_SHIFT) begin
                r_din <= 1'b0;
            end
            if ((r_state == ST_SHIFT) && w_sclk_rise) begin
                r_shift <= {r_shift[c_DATA_BITS-2:0], bus.adc_dout};
            end
            // The ADC converts the channel addressed in the previous frame
            if (w_frame_end) begin
                r_done    <= 1'b1;
                r_data    <= r_shift;
                r_ch      <= r_prev_ch;
                r_prev_ch <= r_ch_lat;
            end
        end
    end

    assign bus.adc_data  = r_data;
    assign bus.adc_ch    = r_ch;
    assign bus.adc_done  = r_done;
    assign bus.adc_state = r_busy;
    assign bus.adc_cs_n  = r_cs_n;
    assign bus.adc_sclk  = w_sclk;
    assign bus.adc_din   = r_din;

endmodule
`default_nettype wire

// File: tb/tb_adc_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_reader
//  Description : Self-checking bench for adc_reader with a behavioural ADC
//                model, a table of back-to-back frames and hand-written
//                reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_reader;

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] word;
        logic [11:0] exp_data;
        logic [2:0]  exp_ch;
        bit          ign;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    adc_reader_if bus ();

    adc_reader #(
        .CLK_DIV (26)
    ) dut (
        .clk_50mhz (clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ADC: DOUT changes after SCLK falls, DIN captured on rise
    logic [15:0] m_word;
    logic [15:0] m_rx;
    int          m_idx;
    int          m_rises;
    logic        m_sclk_q;
    logic        m_cs_q;

    always @(posedge clk) begin
        m_sclk_q <= bus.adc_sclk;
        m_cs_q   <= bus.adc_cs_n;
        if (m_cs_q && !bus.adc_cs_n) begin
            m_idx   <= 0;
            m_rises <= 0;
            m_rx    <= '0;
        end else if (!bus.adc_cs_n) begin
            if (m_sclk_q && !bus.adc_sclk && (m_idx < 16)) begin
                bus.adc_dout <= m_word[15 - m_idx];
                m_idx        <= m_idx + 1;
            end
            if (!m_sclk_q && bus.adc_sclk) begin
                m_rx    <= {m_rx[14:0], bus.adc_din};
                m_rises <= m_rises + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs_n"},  32'(bus.adc_cs_n),  32'd1);
        chk({tag, "_sclk"},  32'(bus.adc_sclk),  32'd1);
        chk({tag, "_din"},   32'(bus.adc_din),   32'd0);
        chk({tag, "_done"},  32'(bus.adc_done),  32'd0);
        chk({tag, "_state"}, 32'(bus.adc_state), 32'd0);
        chk({tag, "_data"},  32'(bus.adc_data),  32'd0);
        chk({tag, "_ch"},    32'(bus.adc_ch),    32'd0);
    endtask

    // One frame: en is driven in the current cycle (cycle 0); returns in
    // cycle 456, the first cycle a new en may be accepted.
    task automatic run_frame(input string tag, input vec_t v);
        int          done_n;
        int          done_cyc;
        int          first_fall;
        int          cs_bad;
        int          busy_bad;
        int          din_bad;
        logic [11:0] d_at;
        logic [2:0]  c_at;
        logic [15:0] exp_ctrl;
        done_n     = 0;
        done_cyc   = -1;
        first_fall = -1;
        cs_bad     = 0;
        busy_bad   = 0;
        din_bad    = 0;
        d_at       = '0;
        c_at       = '0;
        exp_ctrl   = '0;
        exp_ctrl[13:11] = v.ch;
        m_word = v.word;
        bus.en = 1'b1;
        bus.ch = v.ch;
        for (int n = 1; n <= 456; n++) begin
            step();
            if (bus.adc_cs_n !== ((n <= 442) ? 1'b0 : 1'b1)) cs_bad++;
            if (bus.adc_state !== ((n <= 455) ? 1'b1 : 1'b0)) busy_bad++;
            if ((n >= 430) && (bus.adc_din !== 1'b0)) din_bad++;
            if ((first_fall < 0) && (bus.adc_sclk === 1'b0)) first_fall = n;
            if (bus.adc_done === 1'b1) begin
                done_n++;
                done_cyc = n;
                d_at     = bus.adc_data;
                c_at     = bus.adc_ch;
            end
            bus.ch = ~v.ch;
            bus.en = (v.ign && ((n == 100) || (n == 450))) ? 1'b1 : 1'b0;
        end
        bus.en = 1'b0;
        chk({tag, "_done_count"}, 32'(done_n),   32'd1);
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'd443);
        chk({tag, "_data"},       32'(d_at),     32'(v.exp_data));
        chk({tag, "_ch_tag"},     32'(c_at),     32'(v.exp_ch));
        chk({tag, "_data_hold"},  32'(bus.adc_data), 32'(v.exp_data));
        chk({tag, "_cs_window"},  32'(cs_bad),   32'd0);
        chk({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
        chk({tag, "_din_after"},  32'(din_bad),  32'd0);
        chk({tag, "_first_fall"}, 32'(first_fall), 32'd14);
        chk({tag, "_model_rises"}, 32'(m_rises), 32'd16);
        chk({tag, "_model_din_word"}, 32'(m_rx), 32'(exp_ctrl));
        chk({tag, "_model_addr"}, 32'(m_rx[13:11]), 32'(v.ch));
    endtask

    vec_t vecs[5];

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.en   = 1'b0;
        bus.ch   = '0;
        m_word   = '0;
        rst_n    = 1'b1;

        //          ch    word      data     tag   ign
        vecs[0] = '{3'd5, 16'h0A5C, 12'hA5C, 3'd0, 1'b1};
        vecs[1] = '{3'd2, 16'h0123, 12'h123, 3'd5, 1'b0};
        vecs[2] = '{3'd7, 16'hFFFF, 12'hFFF, 3'd2, 1'b0};
        vecs[3] = '{3'd1, 16'h0000, 12'h000, 3'd7, 1'b0};
        vecs[4] = '{3'd6, 16'h8001, 12'h001, 3'd1, 1'b0};

        // Reset held 20 cycles: pins parked, outputs at reset values
        #1 rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("rst_pins_c%0d", i), 32'({bus.adc_sclk, bus.adc_cs_n}), 32'h3);
        end
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        step();
        step();

        // Back-to-back frames straight from the table
        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of SHIFT
        m_word = 16'h0F0F;
        bus.en = 1'b1;
        bus.ch = 3'd4;
        step();
        bus.en = 1'b0;
        bus.ch = 3'd0;
        for (int n = 2; n <= 200; n++) step();
        chk("midrst_pre_cs_n", 32'(bus.adc_cs_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst_async");
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("midrst_hold_c%0d", i),
                32'({bus.adc_done, bus.adc_state, bus.adc_cs_n, bus.adc_sclk}), 32'h3);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("midrst_after_c%0d", i),
                32'({bus.adc_done, bus.adc_state, bus.adc_data}), 32'h0);
        end
        run_frame("post_rst", '{3'd3, 16'h0ABC, 12'hABC, 3'd0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop if the run ever stalls
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
